// File: rtl/gshare_btb_predictor.sv
// Fetch-stage branch predictor: saturating-counter PHT indexed bimodally or by gshare,
// plus a tagged BTB. Both tables are cleared by a sweep after reset before ready rises.
module gshare_btb_predictor #(
    parameter int SCALE  = 10,
    parameter int CNT_W  = 2,
    parameter int HIST_W = 8,
    parameter int TAG_W  = 8,
    parameter int MODE   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    ready,
    input  logic                    bp_oe,
    input  logic [31:0]             bp_pc,
    output logic                    bp_taken,
    output logic [31:0]             bp_target,
    output logic [HIST_W+CNT_W-1:0] bp_data,
    input  logic                    fb_we,
    input  logic [31:0]             fb_pc,
    input  logic                    fb_taken,
    input  logic [31:0]             fb_target,
    input  logic [HIST_W+CNT_W-1:0] fb_data,
    output logic [HIST_W-1:0]       ghr
);

    localparam int DEPTH = 1 << SCALE;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
    } btb_entry_t;

    logic [CNT_W-1:0] pht_mem [DEPTH];
    btb_entry_t       btb_mem [DEPTH];

    state_t                    state_q, state_d;
    logic [SCALE-1:0]          sweep_q, sweep_d;
    logic [HIST_W-1:0]         ghr_q, ghr_d;
    logic                      bp_taken_q, bp_taken_d;
    logic [31:0]               bp_target_q, bp_target_d;
    logic [HIST_W+CNT_W-1:0]   bp_data_q, bp_data_d;

    logic [SCALE-1:0]  bp_bi, bp_pi, fb_bi, fb_pi;
    logic [HIST_W-1:0] bp_hist, fb_hist;
    logic [CNT_W-1:0]  rd_cnt, fb_cnt, fb_cnt_new;
    btb_entry_t        rd_btb;
    logic              bp_hit;

    logic              pht_we, btb_we;
    logic [SCALE-1:0]  pht_waddr, btb_waddr;
    logic [CNT_W-1:0]  pht_wdata;
    btb_entry_t        btb_wdata;

    // Lookup read port: asynchronous read of the pre-edge contents, so a same-cycle
    // feedback write to the same entry is not visible until the next lookup.
    always_comb begin
        bp_bi   = bp_pc[2 +: SCALE];
        bp_hist = (MODE == 1) ? ghr_q : '0;
        bp_pi   = bp_bi ^ SCALE'(bp_hist);
        rd_cnt  = pht_mem[bp_pi];
        rd_btb  = btb_mem[bp_bi];
        bp_hit  = rd_btb.valid && (rd_btb.tag == bp_pc[2 + SCALE +: TAG_W]);
    end

    // Feedback re-derives the index from the history snapshot carried with the branch.
    always_comb begin
        fb_bi   = fb_pc[2 +: SCALE];
        fb_hist = (MODE == 1) ? fb_data[CNT_W +: HIST_W] : '0;
        fb_pi   = fb_bi ^ SCALE'(fb_hist);
        fb_cnt  = fb_data[CNT_W-1:0];
        if (fb_taken) fb_cnt_new = (fb_cnt == CNT_MAX) ? fb_cnt : fb_cnt + CNT_W'(1);
        else          fb_cnt_new = (fb_cnt == '0)      ? fb_cnt : fb_cnt - CNT_W'(1);
    end

    // Single write port per table, shared between the init sweep and feedback.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        pht_we    = 1'b0;
        pht_waddr = fb_pi;
        pht_wdata = fb_cnt_new;
        btb_we    = 1'b0;
        btb_waddr = fb_bi;
        btb_wdata = '{valid: 1'b1, tag: fb_pc[2 + SCALE +: TAG_W], target: fb_target & ~32'h1};
        if (state_q == ST_INIT) begin
            pht_we    = 1'b1;
            pht_waddr = sweep_q;
            pht_wdata = CNT_INIT;
            btb_we    = 1'b1;
            btb_waddr = sweep_q;
            btb_wdata = '0;
        end else if (fb_we) begin
            pht_we = 1'b1;
            btb_we = fb_taken;
        end
    end

    // NOTE: table storage has no reset; the sweep clears it so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (pht_we) pht_mem[pht_waddr] <= pht_wdata;
        if (btb_we) btb_mem[btb_waddr] <= btb_wdata;
    end

    // NOTE: sequential state uses non-blocking assignments only; all next values come from *_d.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            sweep_q     <= '0;
            ghr_q       <= '0;
            bp_taken_q  <= 1'b0;
            bp_target_q <= '0;
            bp_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            ghr_q       <= ghr_d;
            bp_taken_q  <= bp_taken_d;
            bp_target_q <= bp_target_d;
            bp_data_q   <= bp_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == ST_INIT) begin
            sweep_d = sweep_q + SCALE'(1);
            if (sweep_q == '1) state_d = ST_RUN;
        end
    end

    always_comb begin
        ghr_d       = ghr_q;
        bp_taken_d  = bp_taken_q;
        bp_target_d = bp_target_q;
        bp_data_d   = bp_data_q;
        if (state_q == ST_INIT) begin
            ghr_d       = '0;
            bp_taken_d  = 1'b0;
            bp_target_d = '0;
            bp_data_d   = '0;
        end else begin
            if (bp_oe) begin
                bp_taken_d  = bp_hit && rd_cnt[CNT_W-1];
                bp_target_d = bp_hit ? rd_btb.target : '0;
                bp_data_d   = {bp_hist, rd_cnt};
            end
            // Truncating the concatenation also covers the single-bit history case.
            if (fb_we) ghr_d = HIST_W'({ghr_q, fb_taken});
        end
    end

    assign ready     = (state_q == ST_RUN);
    assign bp_taken  = bp_taken_q;
    assign bp_target = bp_target_q;
    assign bp_data   = bp_data_q;
    assign ghr       = ghr_q;

    logic unused_bits;
    assign unused_bits = ^{bp_pc, fb_pc, fb_data};

endmodule
